// File: rtl/uart_alu_host_pkg.sv
// Shared types and constants for the UART ALU host: widths, FSM states,
// byte slot indices and the opcode set understood by the remote ALU.
package uart_alu_host_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX_START = 2'd1,
    ST_TX_WAIT  = 2'd2,
    ST_RX_WAIT  = 2'd3
  } state_e;

  localparam logic [1:0] IDX_A  = 2'd0;
  localparam logic [1:0] IDX_B  = 2'd1;
  localparam logic [1:0] IDX_OP = 2'd2;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_host_if.sv
// Request/response and UART byte-stream signals of the ALU host.
// master = the host block, slave = whoever drives requests and the UART side.
interface uart_alu_host_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_req_valid;
  logic               o_req_ready;
  logic [NB_DATA-1:0] i_dato_A;
  logic [NB_DATA-1:0] i_dato_B;
  logic [NB_OP-1:0]   i_OP;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid;
  logic               o_timeout;
  logic               o_busy;

  modport master (
    input  i_req_valid, i_dato_A, i_dato_B, i_OP, i_tx_done, i_rx_data, i_rx_done,
    output o_req_ready, o_tx_data, o_tx_start, o_result, o_result_valid, o_timeout, o_busy
  );

  modport slave (
    output i_req_valid, i_dato_A, i_dato_B, i_OP, i_tx_done, i_rx_data, i_rx_done,
    input  o_req_ready, o_tx_data, o_tx_start, o_result, o_result_valid, o_timeout, o_busy
  );
endinterface

// File: rtl/uart_alu_host_watchdog_counter.sv
// Per-wait-state watchdog: counts enabled cycles since the last clear and
// flags the last cycle in which a done event may still arrive.
module watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (i_enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  // Depends only on the count so the FSM can use it without a comb loop.
  assign o_expire = i_enable && (cnt_q == LAST);
endmodule

// File: rtl/uart_alu_host.sv
// Host side of the UART ALU byte protocol: sends A, B, OP through a UART
// transmitter, then waits for the single result byte, with a watchdog abort.
module uart_alu_host
  import uart_alu_host_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic            i_clock,
  input  logic            i_reset,
  uart_alu_host_if.master bus
);
  state_e                  state_q, state_d;
  logic [2:0][NB_DATA-1:0] shadow_q, shadow_d;
  logic [1:0]              idx_q, idx_d;
  logic [NB_DATA-1:0]      result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    timeout_q, timeout_d;
  logic                    wd_clear, wd_en, wd_expire;
  logic                    tx_done_ev, rx_done_ev;

  assign tx_done_ev = bus.i_tx_done && (state_q == ST_TX_WAIT);
  assign rx_done_ev = bus.i_rx_done && (state_q == ST_RX_WAIT);

  // Counter restarts at every wait-state entry; TX_START in between clears it too.
  assign wd_en    = (state_q == ST_TX_WAIT) || (state_q == ST_RX_WAIT);
  assign wd_clear = !wd_en || (state_d != state_q);

  watchdog_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .NB_TIMEOUT     (NB_TIMEOUT)
  ) u_wd (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (wd_clear),
    .i_enable (wd_en),
    .o_expire (wd_expire)
  );

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;

  // A done event takes priority over watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.i_req_valid) state_d = ST_TX_START;
      ST_TX_START: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (tx_done_ev)     state_d = (idx_q == IDX_OP) ? ST_RX_WAIT : ST_TX_START;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_RX_WAIT: begin
        if (rx_done_ev || wd_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d       = shadow_q;
    idx_d          = idx_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = wd_expire && !tx_done_ev && !rx_done_ev;
    if (state_q == ST_IDLE && bus.i_req_valid) begin
      shadow_d[IDX_A]  = bus.i_dato_A;
      shadow_d[IDX_B]  = bus.i_dato_B;
      shadow_d[IDX_OP] = NB_DATA'(bus.i_OP);
      idx_d            = IDX_A;
    end
    if (tx_done_ev && idx_q != IDX_OP) idx_d = idx_q + 2'd1;
    if (rx_done_ev) begin
      result_d       = bus.i_rx_data;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      shadow_q       <= '0;
      idx_q          <= IDX_A;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end

  // tx_data follows the slot being sent, so it is stable from start until done.
  always_comb begin
    bus.o_req_ready    = (state_q == ST_IDLE);
    bus.o_busy         = (state_q != ST_IDLE);
    bus.o_tx_start     = (state_q == ST_TX_START);
    bus.o_tx_data      = shadow_q[idx_q];
    bus.o_result       = result_q;
    bus.o_result_valid = result_valid_q;
    bus.o_timeout      = timeout_q;
  end
endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host: stimulus tasks record the expected
// per-cycle protocol timeline; one negedge process compares the DUT to it.
module tb_uart_alu_host;
  import uart_alu_host_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_alu_host_if #(.NB_DATA(8), .NB_OP(6)) bus();

  uart_alu_host #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TO), .NB_TIMEOUT(5)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline
  bit         exp_start [0:4095];
  bit         exp_valid [0:4095];
  bit         exp_to    [0:4095];
  bit         busy_now  = 1'b0;
  bit         txd_on    = 1'b0;
  logic [7:0] txd_exp   = 8'h00;
  logic [7:0] model_res = 8'h00;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_starts = 0;
  logic [7:0] txq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < 4096) begin
      chk("tx_start",     32'(bus.o_tx_start),     32'(exp_start[cyc]));
      chk("result_valid", 32'(bus.o_result_valid), 32'(exp_valid[cyc]));
      chk("timeout",      32'(bus.o_timeout),      32'(exp_to[cyc]));
      chk("req_ready",    32'(bus.o_req_ready),    32'(!busy_now));
      chk("busy",         32'(bus.o_busy),         32'(busy_now));
      chk("result",       32'(bus.o_result),       32'(model_res));
      if (txd_on) chk("tx_data", 32'(bus.o_tx_data), 32'(txd_exp));
    end
    if (bus.o_tx_start) begin
      n_starts++;
      txq.push_back(bus.o_tx_data);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Request accepted at the end of this cycle; start expected next cycle.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    bus.i_dato_A = a; bus.i_dato_B = b; bus.i_OP = op;
    bus.i_req_valid = 1'b1;
    step;
    bus.i_req_valid = 1'b0;
    busy_now = 1'b1;
  endtask

  // Called in a start cycle; done pulsed d cycles after each start.
  task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int d, input bit stray);
    logic [7:0] bs [3];
    bs = '{b0, b1, b2};
    for (int i = 0; i < 3; i++) begin
      exp_start[cyc] = 1'b1;
      txd_on = 1'b1;
      txd_exp = bs[i];
      for (int k = 1; k <= d; k++) begin
        step;
        if (stray && i == 0 && k == 1) begin bus.i_rx_data = 8'hAA; bus.i_rx_done = 1'b1; end
        if (k == 2) bus.i_rx_done = 1'b0;
      end
      bus.i_tx_done = 1'b1;
      step;
      bus.i_tx_done = 1'b0;
    end
    txd_on = 1'b0;
  endtask

  // Called in the RX_WAIT entry cycle; result byte arrives w cycles later.
  task automatic rx_result(input logic [7:0] v, input int w);
    repeat (w) step;
    bus.i_rx_data = v;
    bus.i_rx_done = 1'b1;
    step;
    bus.i_rx_done = 1'b0;
    exp_valid[cyc] = 1'b1;
    model_res = v;
    busy_now = 1'b0;
  endtask

  task automatic rx_timeout;
    repeat (TO) step;
    exp_to[cyc] = 1'b1;
    busy_now = 1'b0;
  endtask

  task automatic tx_timeout(input logic [7:0] b0);
    exp_start[cyc] = 1'b1;
    txd_on = 1'b1;
    txd_exp = b0;
    repeat (TO + 1) step;
    exp_to[cyc] = 1'b1;
    busy_now = 1'b0;
    txd_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int s3;
    bus.i_req_valid = 1'b0; bus.i_dato_A = '0; bus.i_dato_B = '0; bus.i_OP = '0;
    bus.i_tx_done = 1'b0; bus.i_rx_data = '0; bus.i_rx_done = 1'b0;
    repeat (3) step;
    rst = 1'b0;
    step;
    chk("reset_tx_data", 32'(bus.o_tx_data), 32'h00);

    // Basic transaction: 5 + 3 via ADD
    txq.delete();
    accept(8'h05, 8'h03, OP_ADD);
    send_bytes(8'h05, 8'h03, 8'h20, 10, 1'b0);
    rx_result(8'h08, 4);
    chk("t2_nbytes", 32'(txq.size()), 32'd3);
    if (txq.size() == 3) begin
      chk("t2_byte0", 32'(txq[0]), 32'h05);
      chk("t2_byte1", 32'(txq[1]), 32'h03);
      chk("t2_byte2", 32'(txq[2]), 32'h20);
    end
    chk("t2_result", 32'(bus.o_result), 32'h08);

    // Request held high while busy, with new operands: not queued
    txq.delete();
    accept(8'h11, 8'h22, OP_XOR);
    bus.i_dato_A = 8'hFF; bus.i_dato_B = 8'h01; bus.i_OP = OP_SUB;
    bus.i_req_valid = 1'b1;
    send_bytes(8'h11, 8'h22, 8'h26, 3, 1'b0);
    rx_result(8'h33, 2);
    s3 = n_starts;
    step;
    bus.i_req_valid = 1'b0;
    busy_now = 1'b1;
    send_bytes(8'hFF, 8'h01, 8'h22, 2, 1'b0);
    rx_result(8'hFE, 0);
    chk("t3_starts_first", 32'(txq.size() >= 3 ? 3 : txq.size()), 32'd3);
    chk("t3_starts_total", 32'(n_starts - s3), 32'd3);
    if (txq.size() == 6) begin
      chk("t3_first_a",  32'(txq[0]), 32'h11);
      chk("t3_second_a", 32'(txq[3]), 32'hFF);
    end

    // RX watchdog, then TX watchdog; result must hold
    accept(8'h01, 8'h02, OP_AND);
    send_bytes(8'h01, 8'h02, 8'h24, 2, 1'b0);
    rx_timeout();
    step;
    chk("t4_rx_to_result", 32'(bus.o_result), 32'hFE);
    accept(8'h03, 8'h04, OP_OR);
    tx_timeout(8'h03);
    step;
    chk("t4_tx_to_result", 32'(bus.o_result), 32'hFE);

    // Stray bytes ignored; byte in the expiry cycle still accepted
    bus.i_rx_data = 8'hAA; bus.i_rx_done = 1'b1;
    step;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b1;
    step;
    bus.i_tx_done = 1'b0;
    step;
    accept(8'h07, 8'h08, OP_NOR);
    send_bytes(8'h07, 8'h08, 8'h27, 4, 1'b1);
    rx_result(8'h5A, TO - 1);
    repeat (TO + 2) step;
    chk("t5_result", 32'(bus.o_result), 32'h5A);

    // Reset in the middle of a byte sequence
    accept(8'h09, 8'h0A, OP_SRL);
    exp_start[cyc] = 1'b1;
    txd_on = 1'b1;
    txd_exp = 8'h09;
    step;
    step;
    rst = 1'b1;
    model_res = 8'h00;
    busy_now = 1'b0;
    txd_on = 1'b0;
    #1;
    chk("rst_mid_tx_data", 32'(bus.o_tx_data), 32'h00);
    chk("rst_mid_result",  32'(bus.o_result),  32'h00);
    step;
    step;
    rst = 1'b0;
    step;
    bus.i_tx_done = 1'b1;
    step;
    bus.i_tx_done = 1'b0;
    repeat (4) step;

    // Recovery transaction: 0x0F OR 0xF0
    accept(8'h0F, 8'hF0, OP_OR);
    send_bytes(8'h0F, 8'hF0, 8'h25, 1, 1'b0);
    rx_result(8'hFF, 1);
    step;
    chk("final_result", 32'(bus.o_result), 32'hFF);

    repeat (3) step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
